// File: rtl/speaker_dac_serializer.sv
// Streams stereo 24-bit sample pairs to a WM8731 DAC in DSP mode B (slave). BCLK and DACLRCK
// are generated here. Pairs are buffered in a 2-entry FIFO, and one pair is sent per audio frame.
module speaker_dac_serializer #(
   parameter int BCLK_DIV     = 4,
   parameter int FRAME_CYCLES = 6250
) (
   input  logic        osc_50,
   input  logic        reset_50m,
   input  logic        i2c_audio_done,
   input  logic        speaker_valid,
   output logic        speaker_ready,
   input  logic [23:0] speaker_left,
   input  logic [23:0] speaker_right,
   output logic        AUD_BCLK,
   output logic        AUD_DACLRCK,
   output logic        AUD_DACDAT,
   output logic [15:0] underrun_count
);
   localparam int FC_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam int HC_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_CYCLES - 1);
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(BCLK_DIV - 1);

   typedef enum logic [1:0] {WAIT_CFG, IDLE, START, SHIFT} state_t;

   state_t          state_q, state_d;
   logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [HC_W-1:0] half_cnt_q, half_cnt_d;
   logic [5:0]      bit_cnt_q, bit_cnt_d;
   logic [47:0]     shift_q, shift_d;
   logic [47:0]     fifo_mem_q [2];
   logic [47:0]     fifo_mem_d [2];
   logic            rd_ptr_q, rd_ptr_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic [1:0]      occ_q, occ_d;
   logic            ready_q, ready_d;
   logic            bclk_q, bclk_d;
   logic            lrck_q, lrck_d;
   logic            dat_q, dat_d;
   logic [15:0]     underrun_count_q, underrun_count_d;
   logic            push, pop;
   logic [47:0]     load_word;

   assign push      = speaker_valid && ready_q;
   assign pop       = (state_q == START) && (occ_q != 2'd0);
   assign load_word = pop ? fifo_mem_q[rd_ptr_q] : 48'd0;

   // A push during the pop cycle lands in the write slot only, so the pop never sees it.
   always_comb begin
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      if (push) begin
         fifo_mem_d[wr_ptr_q] = {speaker_left, speaker_right};
         wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_comb begin
      state_d          = state_q;
      frame_cnt_d      = frame_cnt_q;
      half_cnt_d       = half_cnt_q;
      bit_cnt_d        = bit_cnt_q;
      shift_d          = shift_q;
      bclk_d           = bclk_q;
      lrck_d           = lrck_q;
      dat_d            = dat_q;
      underrun_count_d = underrun_count_q;

      if (state_q != WAIT_CFG) begin
         frame_cnt_d = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + 1'b1;
      end

      case (state_q)
         WAIT_CFG: begin
            frame_cnt_d = '0;
            bclk_d      = 1'b0;
            lrck_d      = 1'b0;
            dat_d       = 1'b0;
            if (i2c_audio_done) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            // START lands on frame count 0, one full frame after the previous START.
            if (frame_cnt_q == FC_LAST) begin
               state_d = START;
            end
         end
         START: begin
            if (!pop && underrun_count_q != 16'hffff) begin
               underrun_count_d = underrun_count_q + 16'd1;
            end
            shift_d    = load_word;
            lrck_d     = 1'b1;
            bclk_d     = 1'b0;
            dat_d      = load_word[47];
            bit_cnt_d  = 6'd0;
            half_cnt_d = '0;
            state_d    = SHIFT;
         end
         SHIFT: begin
            if (half_cnt_q == HC_LAST) begin
               half_cnt_d = '0;
               if (!bclk_q) begin
                  bclk_d    = 1'b1;
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end else begin
                  bclk_d = 1'b0;
                  lrck_d = 1'b0;
                  if (bit_cnt_q == 6'd48) begin
                     dat_d   = 1'b0;
                     state_d = IDLE;
                  end else begin
                     shift_d = {shift_q[46:0], 1'b0};
                     dat_d   = shift_q[46];
                  end
               end
            end else begin
               half_cnt_d = half_cnt_q + 1'b1;
            end
         end
         default: state_d = WAIT_CFG;
      endcase

      ready_d = (state_d != WAIT_CFG) && (occ_d != 2'd2);
   end

   always_ff @(posedge osc_50 or posedge reset_50m) begin
      if (reset_50m) begin
         state_q          <= WAIT_CFG;
         frame_cnt_q      <= '0;
         half_cnt_q       <= '0;
         bit_cnt_q        <= 6'd0;
         shift_q          <= 48'd0;
         fifo_mem_q[0]    <= 48'd0;
         fifo_mem_q[1]    <= 48'd0;
         rd_ptr_q         <= 1'b0;
         wr_ptr_q         <= 1'b0;
         occ_q            <= 2'd0;
         ready_q          <= 1'b0;
         bclk_q           <= 1'b0;
         lrck_q           <= 1'b0;
         dat_q            <= 1'b0;
         underrun_count_q <= 16'd0;
      end else begin
         state_q          <= state_d;
         frame_cnt_q      <= frame_cnt_d;
         half_cnt_q       <= half_cnt_d;
         bit_cnt_q        <= bit_cnt_d;
         shift_q          <= shift_d;
         fifo_mem_q       <= fifo_mem_d;
         rd_ptr_q         <= rd_ptr_d;
         wr_ptr_q         <= wr_ptr_d;
         occ_q            <= occ_d;
         ready_q          <= ready_d;
         bclk_q           <= bclk_d;
         lrck_q           <= lrck_d;
         dat_q            <= dat_d;
         underrun_count_q <= underrun_count_d;
      end
   end

   assign speaker_ready  = ready_q;
   assign AUD_BCLK       = bclk_q;
   assign AUD_DACLRCK    = lrck_q;
   assign AUD_DACDAT     = dat_q;
   assign underrun_count = underrun_count_q;
endmodule

// File: tb/tb_speaker_dac_serializer.sv
// Bench for speaker_dac_serializer: a BCLK-edge bus model decodes frames. Table vectors and
// hand-written sequences cover config gating, backpressure, underrun and reset.
module tb_speaker_dac_serializer;
   localparam int  DIV    = 4;
   localparam int  FRAME  = 500;
   localparam time FRAME_T = 5000;  // FRAME cycles at 10 ns
   localparam time SPAN_T  = 3760;  // 47 BCLK periods of 80 ns

   logic        osc_50 = 1'b0;
   logic        reset_50m;
   logic        i2c_audio_done;
   logic        speaker_valid;
   logic        speaker_ready;
   logic [23:0] speaker_left;
   logic [23:0] speaker_right;
   logic        AUD_BCLK;
   logic        AUD_DACLRCK;
   logic        AUD_DACDAT;
   logic [15:0] underrun_count;

   speaker_dac_serializer #(.BCLK_DIV(DIV), .FRAME_CYCLES(FRAME)) dut (
      .osc_50         (osc_50),
      .reset_50m      (reset_50m),
      .i2c_audio_done (i2c_audio_done),
      .speaker_valid  (speaker_valid),
      .speaker_ready  (speaker_ready),
      .speaker_left   (speaker_left),
      .speaker_right  (speaker_right),
      .AUD_BCLK       (AUD_BCLK),
      .AUD_DACLRCK    (AUD_DACLRCK),
      .AUD_DACDAT     (AUD_DACDAT),
      .underrun_count (underrun_count)
   );

   always #5 osc_50 = ~osc_50;

   int n_cmp = 0;
   int n_bad = 0;

   // Bus model: samples DACDAT/LRCK on rising BCLK like the codec does.
   int          bclk_rises = 0;
   int          stray_edges = 0;
   int          lrck_extra = 0;
   bit          cap_on = 0;
   int          cap_idx = 0;
   logic [47:0] cap_bits = 48'd0;
   time         cap_t0 = 0;
   time         lrck_rise_t = 0;
   logic [47:0] frames_q [$];
   time         t0_q [$];
   time         span_q [$];

   always @(posedge AUD_BCLK) begin
      bclk_rises++;
      if (AUD_DACLRCK) begin
         if (cap_on) lrck_extra++;
         cap_on   = 1;
         cap_idx  = 1;
         cap_bits = {47'd0, AUD_DACDAT};
         cap_t0   = $time;
      end else if (cap_on) begin
         cap_bits = {cap_bits[46:0], AUD_DACDAT};
         cap_idx++;
      end else begin
         stray_edges++;
      end
      if (cap_on && cap_idx == 48) begin
         frames_q.push_back(cap_bits);
         t0_q.push_back(cap_t0);
         span_q.push_back($time - cap_t0);
         cap_on = 0;
      end
   end

   always @(posedge AUD_DACLRCK) lrck_rise_t = $time;

   task automatic tick(input int n);
      repeat (n) @(posedge osc_50);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic push_pair(input logic [23:0] l, input logic [23:0] r,
                            output int waited, output logic lrck_seen);
      logic rdy;
      rdy = 1'b0;
      waited = 0;
      lrck_seen = 1'b0;
      speaker_left = l;
      speaker_right = r;
      speaker_valid = 1'b1;
      while (!rdy && waited < 2000) begin
         rdy = speaker_ready;
         lrck_seen = AUD_DACLRCK;
         tick(1);
         if (!rdy) waited++;
      end
      speaker_valid = 1'b0;
      chk("push_accepted", rdy, 1);
   endtask

   task automatic wait_frame(output logic [47:0] bits, output time t0, output time span);
      int n;
      n = 0;
      while (frames_q.size() == 0 && n < 3 * FRAME) begin
         tick(1);
         n++;
      end
      chk("frame_arrived", frames_q.size() != 0, 1);
      if (frames_q.size() != 0) begin
         bits = frames_q.pop_front();
         t0   = t0_q.pop_front();
         span = span_q.pop_front();
      end else begin
         bits = 48'hx;
         t0   = 0;
         span = 0;
      end
   endtask

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic [47:0] exp_bits;
   } vec_t;

   vec_t        vecs [5];
   logic [47:0] bits;
   time         t0, span, prev_t0;
   int          waited, k;
   logic        lrck_seen;
   logic [23:0] t4_l [3];
   logic [23:0] t4_r [3];
   logic [47:0] t4_exp [3];
   time         target;

   initial begin
      vecs[0] = '{24'h800001, 24'h7ffffe, 48'h800001_7ffffe};
      vecs[1] = '{24'h123456, 24'habcdef, 48'h123456_abcdef};
      vecs[2] = '{24'hffffff, 24'h000000, 48'hffffff_000000};
      vecs[3] = '{24'h000000, 24'hffffff, 48'h000000_ffffff};
      vecs[4] = '{24'ha5a5a5, 24'h5a5a5a, 48'ha5a5a5_5a5a5a};
      t4_l = '{24'h111111, 24'h222222, 24'h333333};
      t4_r = '{24'h999999, 24'haaaaaa, 24'hbbbbbb};
      t4_exp = '{48'h111111_999999, 48'h222222_aaaaaa, 48'h333333_bbbbbb};

      reset_50m = 1'b1;
      i2c_audio_done = 1'b0;
      speaker_valid = 1'b0;
      speaker_left = 24'd0;
      speaker_right = 24'd0;
      tick(3);
      chk("rst_ready", speaker_ready, 0);
      chk("rst_bclk", AUD_BCLK, 0);
      chk("rst_lrck", AUD_DACLRCK, 0);
      chk("rst_dat", AUD_DACDAT, 0);
      chk("rst_underrun", underrun_count, 0);
      reset_50m = 1'b0;

      // Config gate: nothing moves until i2c_audio_done.
      tick(20000);
      chk("cfg_gate_bclk_rises", bclk_rises, 0);
      chk("cfg_gate_ready", speaker_ready, 0);
      i2c_audio_done = 1'b1;
      tick(1);
      i2c_audio_done = 1'b0;  // sticky inside the DUT
      chk("ready_after_cfg", speaker_ready, 1);
      push_pair(vecs[0].l, vecs[0].r, waited, lrck_seen);
      k = 1;
      while (!AUD_DACLRCK && k < 2000) begin
         tick(1);
         k++;
      end
      chk("first_start_cycles", k, FRAME + 1);
      wait_frame(bits, t0, span);
      chk("t3_bits", bits, 48'h800001_7ffffe);
      chk("t3_bclk_span", span, SPAN_T);
      chk("t3_underrun", underrun_count, 0);
      prev_t0 = t0;

      // Table-driven frames, each pushed between bursts.
      for (int i = 0; i < 5; i++) begin
         push_pair(vecs[i].l, vecs[i].r, waited, lrck_seen);
         wait_frame(bits, t0, span);
         chk($sformatf("vec%0d_bits", i), bits, vecs[i].exp_bits);
         chk($sformatf("vec%0d_frame_period", i), t0 - prev_t0, FRAME_T);
         prev_t0 = t0;
      end
      chk("table_underrun", underrun_count, 0);

      // Backpressure: third pair waits until the next START frees a slot.
      push_pair(t4_l[0], t4_r[0], waited, lrck_seen);
      push_pair(t4_l[1], t4_r[1], waited, lrck_seen);
      chk("t4_ready_full", speaker_ready, 0);
      push_pair(t4_l[2], t4_r[2], waited, lrck_seen);
      chk("t4_accept_after_start", lrck_seen, 1);
      for (int i = 0; i < 3; i++) begin
         wait_frame(bits, t0, span);
         chk($sformatf("t4_frame%0d_bits", i), bits, t4_exp[i]);
         chk($sformatf("t4_frame%0d_period", i), t0 - prev_t0, FRAME_T);
         prev_t0 = t0;
      end
      chk("t4_underrun", underrun_count, 0);

      // Underrun: three empty frames.
      for (int i = 0; i < 3; i++) begin
         wait_frame(bits, t0, span);
         chk($sformatf("t5_zero%0d_bits", i), bits, 48'd0);
         chk($sformatf("t5_zero%0d_underrun", i), underrun_count, i + 1);
      end

      // Push exactly in the START cycle with an empty FIFO.
      target = lrck_rise_t + FRAME_T - 10 + 1;
      k = 0;
      while ($time < target && k < 2 * FRAME) begin
         tick(1);
         k++;
      end
      speaker_left = 24'h13579b;
      speaker_right = 24'h2468ac;
      speaker_valid = 1'b1;
      chk("t6_ready_in_start", speaker_ready, 1);
      tick(1);
      speaker_valid = 1'b0;
      chk("t6_start_edge", AUD_DACLRCK, 1);
      wait_frame(bits, t0, span);
      chk("t6_zero_bits", bits, 48'd0);
      chk("t6_underrun", underrun_count, 4);
      wait_frame(bits, t0, span);
      chk("t6_next_bits", bits, 48'h13579b_2468ac);
      chk("t6_underrun_hold", underrun_count, 4);

      // Saturation from a preloaded count.
      force dut.underrun_count_q = 16'hfffe;
      tick(2);
      release dut.underrun_count_q;
      for (int i = 0; i < 3; i++) begin
         wait_frame(bits, t0, span);
         chk($sformatf("t5_sat%0d_bits", i), bits, 48'd0);
         chk($sformatf("t5_sat%0d_underrun", i), underrun_count, 16'hffff);
      end

      // Reset mid-SHIFT clears outputs immediately.
      push_pair(24'hffffff, 24'hffffff, waited, lrck_seen);
      k = 0;
      while (!AUD_DACLRCK && k < 2 * FRAME) begin
         tick(1);
         k++;
      end
      tick(100);
      chk("t1_pre_dat", AUD_DACDAT, 1);
      #3;
      reset_50m = 1'b1;
      #1;
      chk("t1_bclk", AUD_BCLK, 0);
      chk("t1_lrck", AUD_DACLRCK, 0);
      chk("t1_dat", AUD_DACDAT, 0);
      chk("t1_ready", speaker_ready, 0);
      chk("t1_underrun", underrun_count, 0);
      tick(2);
      reset_50m = 1'b0;
      tick(5);
      chk("t1_wait_cfg_ready", speaker_ready, 0);

      chk("stray_bclk_edges", stray_edges, 0);
      chk("lrck_extra_edges", lrck_extra, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
